// File: rtl/fma16_pkg.sv
// Shared types, constants and binary16 field helpers for the fma16 datapath and its dot-product sequencer.
// Declarations only; no logic, no latency, no backpressure.
package fma16_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} dot_state_t;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;
  localparam logic [15:0] FP16_ONE      = 16'h3C00;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [1:0] RM_RNE = 2'd0;
  localparam logic [1:0] RM_RTZ = 2'd1;
  localparam logic [1:0] RM_RDN = 2'd2;
  localparam logic [1:0] RM_RUP = 2'd3;

  function automatic logic is_nan(input logic [15:0] v);
    return (&v[14:10]) && (|v[9:0]);
  endfunction

  function automatic logic is_inf(input logic [15:0] v);
    return (&v[14:10]) && !(|v[9:0]);
  endfunction

  function automatic logic is_zero(input logic [15:0] v);
    return !(|v[14:0]);
  endfunction

  // Significand with hidden bit; subnormals share the exponent of the smallest normal.
  function automatic logic [10:0] mant(input logic [15:0] v);
    return {|v[14:10], v[9:0]};
  endfunction

  function automatic logic [4:0] eexp(input logic [15:0] v);
    return (v[14:10] == 5'd0) ? 5'd1 : v[14:10];
  endfunction

endpackage

// File: rtl/fma16.sv
// Combinational binary16 fused multiply-add, r = (+/-)x*y + (+/-)z, single rounding, flags {NV,OF,UF,NX}.
// Zero latency, no handshake: the caller owns any registering and flow control.
module fma16
  import fma16_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  logic [15:0] b, c;
  logic        ps, zs, rs, snan, anynan, inv, ovf, ovf_inf, tiny, g, st, inc;
  logic [21:0] prod;
  logic [6:0]  psh, zsh, p, lsb, base;
  logic [81:0] pm, zm, mag, rem_mask;
  logic [11:0] kept, rounded;
  logic [16:0] enc;

  assign b = mul ? y : FP16_ONE;
  assign c = add ? z : FP16_NEG_ZERO;

  // Exact sum held as an 82-bit fixed-point magnitude with LSB 2^-48, so only one rounding step exists.
  always_comb begin
    ps   = x[15] ^ b[15] ^ negp;
    zs   = c[15] ^ (negz & add);
    prod = mant(x) * mant(b);
    psh  = 7'(eexp(x)) + 7'(eexp(b)) - 7'd2;
    zsh  = 7'(eexp(c)) + 7'd23;
    pm   = 82'(prod) << psh;
    zm   = 82'(mant(c)) << zsh;
    rs   = ps;
    if (ps == zs) begin
      mag = pm + zm;
    end else if (pm >= zm) begin
      mag = pm - zm;
    end else begin
      mag = zm - pm;
      rs  = zs;
    end

    p = '0;
    for (int i = 0; i < 82; i++) begin
      if (mag[i]) p = 7'(i);
    end
    tiny     = (p < 7'd34);
    lsb      = tiny ? 7'd24 : p - 7'd10;
    kept     = 12'(mag >> lsb);
    rem_mask = (82'd1 << (lsb - 7'd1)) - 82'd1;
    g        = |(mag & (82'd1 << (lsb - 7'd1)));
    st       = |(mag & rem_mask);

    unique case (roundmode)
      RM_RNE:  inc = g & (st | kept[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = rs & (g | st);
      default: inc = ~rs & (g | st);
    endcase
    rounded = kept + {11'd0, inc};
    // Hidden bit of a normal significand carries into the exponent field, so subtract one up front.
    base    = tiny ? 7'd0 : p - 7'd34;
    enc     = {base, 10'd0} + {5'd0, rounded};
    ovf     = (enc[16:10] >= 7'd31);
    ovf_inf = (roundmode == RM_RNE) || ((roundmode == RM_RDN) && rs) || ((roundmode == RM_RUP) && !rs);
  end

  always_comb begin
    snan   = (is_nan(x) & ~x[9]) | (is_nan(b) & ~b[9]) | (is_nan(c) & ~c[9]);
    anynan = is_nan(x) | is_nan(b) | is_nan(c);
    inv    = (is_inf(x) & is_zero(b)) | (is_inf(b) & is_zero(x))
           | ((is_inf(x) | is_inf(b)) & is_inf(c) & (ps != zs));
    result = FP16_POS_ZERO;
    flags  = '0;
    if (anynan || inv) begin
      result        = FP16_QNAN;
      flags[FLG_NV] = snan | inv;
    end else if (is_inf(x) || is_inf(b)) begin
      result = {ps, 15'h7C00};
    end else if (is_inf(c)) begin
      result = {zs, c[14:0]};
    end else if (mag == '0) begin
      result = {(ps == zs) ? ps : (roundmode == RM_RDN), 15'd0};
    end else if (ovf) begin
      result        = ovf_inf ? {rs, 15'h7C00} : {rs, 15'h7BFF};
      flags[FLG_OF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else begin
      result        = {rs, enc[14:0]};
      flags[FLG_UF] = tiny & (g | st);
      flags[FLG_NX] = g | st;
    end
  end

endmodule

// File: rtl/fma16_dotctl.sv
// Half-precision dot-product sequencer: one operand pair per cycle into fma16 with z fed back from acc.
// acc visible the cycle after each handshake; in_ready depends on state only, so stalls just hold everything.
module fma16_dotctl
  import fma16_pkg::*;
#(
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [LENW-1:0] len,
  input  logic [1:0]      roundmode,
  input  logic            negp,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     x,
  input  logic [15:0]     y,
  output logic            busy,
  output logic            done,
  output logic [15:0]     acc,
  output logic [3:0]      flags
);

  dot_state_t      state, state_nxt;
  logic [LENW-1:0] cnt, len_q;
  logic [1:0]      rm_q;
  logic            negp_q, accept, hs;
  logic [15:0]     fma_res;
  logic [3:0]      fma_flags;

  fma16 u_fma16 (
    .x         (x),
    .y         (y),
    .z         (acc),
    .mul       (1'b1),
    .add       (1'b1),
    .negp      (negp_q),
    .negz      (1'b0),
    .roundmode (rm_q),
    .result    (fma_res),
    .flags     (fma_flags)
  );

  assign hs = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == len_q - 1'b1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      len_q  <= '0;
      rm_q   <= RM_RNE;
      negp_q <= 1'b0;
      acc    <= FP16_POS_ZERO;
      flags  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        len_q  <= len;
        rm_q   <= roundmode;
        negp_q <= negp;
        cnt    <= '0;
        acc    <= FP16_POS_ZERO;
        flags  <= '0;
      end else if (hs) begin
        acc   <= fma_res;
        flags <= flags | fma_flags;
        cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fma16_dotctl.sv
// Directed bench for fma16_dotctl: hand-computed binary16 dot products, stalls, zero length, reset abort.
module tb_fma16_dotctl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [1:0]  roundmode = 2'd0;
  logic        negp = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        busy;
  logic        done;
  logic [15:0] acc;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  fma16_dotctl #(.LENW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .roundmode (roundmode),
    .negp      (negp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .acc       (acc),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge; returns in cycle 1 of the operation.
  task automatic go(input logic [7:0] l, input logic [1:0] rm, input logic np);
    start     = 1'b1;
    len       = l;
    roundmode = rm;
    negp      = np;
    tick();
    start = 1'b0;
  endtask

  task automatic offer(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    x        = a;
    y        = b;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_rdy", 16'(in_ready), 16'd0);
    chk("rst_acc", acc, 16'h0000);
    chk("rst_flags", 16'(flags), 16'd0);
    reset = 1'b0;
    tick();

    // Two pairs back to back: 1*2 + 2*3 = 8
    go(8'd2, 2'd0, 1'b0);
    chk("t1_rdy", 16'(in_ready), 16'd1);
    chk("t1_busy", 16'(busy), 16'd1);
    offer(16'h3C00, 16'h4000);
    tick();
    chk("t1_acc1", acc, 16'h4000);
    chk("t1_early", 16'(done), 16'd0);
    offer(16'h4000, 16'h4200);
    tick();
    in_valid = 1'b0;
    chk("t1_done", 16'(done), 16'd1);
    chk("t1_acc", acc, 16'h4800);
    chk("t1_flags", 16'(flags), 16'd0);
    chk("t1_rdy_done", 16'(in_ready), 16'd0);
    tick();
    chk("t1_idle_busy", 16'(busy), 16'd0);
    chk("t1_idle_done", 16'(done), 16'd0);
    chk("t1_hold", acc, 16'h4800);

    // Same vectors with a three-cycle gap between the pairs
    go(8'd2, 2'd0, 1'b0);
    offer(16'h3C00, 16'h4000);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_gap_rdy", 16'(in_ready), 16'd1);
      chk("t2_gap_acc", acc, 16'h4000);
      chk("t2_gap_done", 16'(done), 16'd0);
      tick();
    end
    offer(16'h4000, 16'h4200);
    tick();
    in_valid = 1'b0;
    chk("t2_done", 16'(done), 16'd1);
    chk("t2_acc", acc, 16'h4800);
    tick();

    // Zero length completes immediately and clears the previous result
    go(8'd0, 2'd0, 1'b0);
    chk("t3_done", 16'(done), 16'd1);
    chk("t3_rdy", 16'(in_ready), 16'd0);
    chk("t3_acc", acc, 16'h0000);
    chk("t3_flags", 16'(flags), 16'd0);
    tick();
    chk("t3_idle", 16'(busy), 16'd0);

    // Negated product: -(1*1) + 0 = -1
    go(8'd1, 2'd0, 1'b1);
    offer(16'h3C00, 16'h3C00);
    tick();
    in_valid = 1'b0;
    chk("t4_done", 16'(done), 16'd1);
    chk("t4_acc", acc, 16'hBC00);
    chk("t4_flags", 16'(flags), 16'd0);
    tick();

    // 65504^2 overflows: RNE gives +Inf with OF|NX, sticky into IDLE
    go(8'd1, 2'd0, 1'b0);
    offer(16'h7BFF, 16'h7BFF);
    tick();
    in_valid = 1'b0;
    chk("t5_done", 16'(done), 16'd1);
    chk("t5_acc", acc, 16'h7C00);
    chk("t5_flags", 16'(flags), 16'b0101);
    tick();
    chk("t5_sticky", 16'(flags), 16'b0101);
    chk("t5_hold", acc, 16'h7C00);

    // Same overflow under round-toward-zero saturates to max finite
    go(8'd1, 2'd1, 1'b0);
    offer(16'h7BFF, 16'h7BFF);
    tick();
    in_valid = 1'b0;
    chk("t5z_acc", acc, 16'h7BFF);
    chk("t5z_flags", 16'(flags), 16'b0101);
    tick();

    // start with len=1 while running len=3 must be ignored: 1+1+1 = 3
    go(8'd3, 2'd0, 1'b0);
    offer(16'h3C00, 16'h3C00);
    start = 1'b1;
    len   = 8'd1;
    tick();
    start = 1'b0;
    chk("t6_acc1", acc, 16'h3C00);
    chk("t6_done_c2", 16'(done), 16'd0);
    tick();
    chk("t6_acc2", acc, 16'h4000);
    chk("t6_done_c3", 16'(done), 16'd0);
    tick();
    in_valid = 1'b0;
    chk("t6_done", 16'(done), 16'd1);
    chk("t6_acc", acc, 16'h4200);
    tick();

    // Reset after the first (overflowing) handshake aborts and clears everything
    go(8'd2, 2'd0, 1'b0);
    offer(16'h7BFF, 16'h7BFF);
    tick();
    chk("t7_flags_pre", 16'(flags), 16'b0101);
    reset = 1'b1;
    offer(16'h4000, 16'h4200);
    tick();
    chk("t7_busy", 16'(busy), 16'd0);
    chk("t7_rdy", 16'(in_ready), 16'd0);
    chk("t7_done", 16'(done), 16'd0);
    chk("t7_acc", acc, 16'h0000);
    chk("t7_flags", 16'(flags), 16'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("t7_still_idle", 16'(busy), 16'd0);

    go(8'd2, 2'd0, 1'b0);
    offer(16'h3C00, 16'h4000);
    tick();
    offer(16'h4000, 16'h4200);
    tick();
    in_valid = 1'b0;
    chk("t7_rerun_done", 16'(done), 16'd1);
    chk("t7_rerun_acc", acc, 16'h4800);
    chk("t7_rerun_flags", 16'(flags), 16'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
